// File: rtl/sap1_pkg.sv
// Shared SAP-1 sequencer constants: opcodes, control-word bit positions,
// one-hot T-states and the fixed fetch control words.
package sap1_pkg;

   localparam int OP_W = 4;
   localparam int CW_W = 12;

   localparam logic [OP_W-1:0] OP_LDA = 4'h0;
   localparam logic [OP_W-1:0] OP_ADD = 4'h1;
   localparam logic [OP_W-1:0] OP_SUB = 4'h2;
   localparam logic [OP_W-1:0] OP_OUT = 4'hE;
   localparam logic [OP_W-1:0] OP_HLT = 4'hF;

   localparam int CW_CP = 0;
   localparam int CW_EP = 1;
   localparam int CW_LM = 2;
   localparam int CW_CE = 3;
   localparam int CW_LI = 4;
   localparam int CW_EI = 5;
   localparam int CW_LA = 6;
   localparam int CW_EA = 7;
   localparam int CW_SU = 8;
   localparam int CW_EU = 9;
   localparam int CW_LB = 10;
   localparam int CW_LO = 11;

   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T2 = 6'b000010;
   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T4 = 6'b001000;
   localparam logic [5:0] T5 = 6'b010000;
   localparam logic [5:0] T6 = 6'b100000;

   function automatic logic [CW_W-1:0] cw(input int idx);
      return CW_W'(1) << idx;
   endfunction

   localparam logic [CW_W-1:0] CW_FETCH_T1 = cw(CW_EP) | cw(CW_LM);
   localparam logic [CW_W-1:0] CW_FETCH_T2 = cw(CW_CP);
   localparam logic [CW_W-1:0] CW_FETCH_T3 = cw(CW_CE) | cw(CW_LI);

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot ring counter: resets to T1, freezes while i_hold,
// and jumps back to T1 on i_restart.
module sap1_ring_counter
   import sap1_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_hold,
   input  logic       i_restart,
   output logic [5:0] o_state
);

   logic [5:0] r_state;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= T1;
      end else if (!i_hold) begin
         r_state <= i_restart ? T1 : {r_state[4:0], r_state[5]};
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/sap1_sequencer.sv
// SAP-1 microcoded sequencer: T-state ring plus opcode decode into the control word and halt.
// Optional SAP1_SEQ_EARLY_END_EN shortens LDA/OUT/undefined instruction cycles.
module sap1_sequencer
   import sap1_pkg::*;
#(
   parameter int OP_W_P = OP_W,
   parameter int CW_W_P = CW_W
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [OP_W_P-1:0] opcode_i,
   output logic              hltn_o,
   output logic [CW_W_P-1:0] ctrl_word_o,
   output logic [5:0]        t_state_o
);

   logic [5:0]      w_t;
   logic [CW_W-1:0] w_ctrl;
   logic            w_hlt_now;
   logic            w_hold;
   logic            w_restart;
   logic            r_halt;

   // Opcode is only meaningful once the IR has been loaded, i.e. from T4 on.
   assign w_hlt_now = (w_t == T4) && (opcode_i == OP_HLT);
   assign w_hold    = r_halt | w_hlt_now;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_halt <= 1'b0;
      end else if (w_hlt_now) begin
         r_halt <= 1'b1;
      end
   end

`ifdef SAP1_SEQ_EARLY_END_EN
   logic w_undef;
   assign w_undef   = (opcode_i >= 4'h3) && (opcode_i <= 4'hD);
   assign w_restart = ((w_t == T5) && (opcode_i == OP_LDA)) ||
                      ((w_t == T4) && ((opcode_i == OP_OUT) || w_undef));
`else
   assign w_restart = 1'b0;
`endif

   sap1_ring_counter u_ring (
      .i_clk     (clk_i),
      .i_rst_n   (rstn_i),
      .i_hold    (w_hold),
      .i_restart (w_restart),
      .o_state   (w_t)
   );

   always_comb begin
      w_ctrl = '0;
      unique case (w_t)
         T1: w_ctrl = CW_FETCH_T1;
         T2: w_ctrl = CW_FETCH_T2;
         T3: w_ctrl = CW_FETCH_T3;
         T4: begin
            if (opcode_i == OP_LDA || opcode_i == OP_ADD || opcode_i == OP_SUB)
               w_ctrl = cw(CW_EI) | cw(CW_LM);
            else if (opcode_i == OP_OUT)
               w_ctrl = cw(CW_EA) | cw(CW_LO);
         end
         T5: begin
            if (opcode_i == OP_LDA)
               w_ctrl = cw(CW_CE) | cw(CW_LA);
            else if (opcode_i == OP_ADD || opcode_i == OP_SUB)
               w_ctrl = cw(CW_CE) | cw(CW_LB);
         end
         T6: begin
            if (opcode_i == OP_ADD)
               w_ctrl = cw(CW_EU) | cw(CW_LA);
            else if (opcode_i == OP_SUB)
               w_ctrl = cw(CW_SU) | cw(CW_EU) | cw(CW_LA);
         end
         default: w_ctrl = '0;
      endcase
      if (r_halt) w_ctrl = '0;
   end

   assign ctrl_word_o = w_ctrl;
   assign hltn_o      = ~w_hold;
   assign t_state_o   = w_t;

endmodule

// File: tb/tb_sap1_sequencer.sv
// Self-checking bench for sap1_sequencer against an instruction-level reference model.
module tb_sap1_sequencer;

   logic        clk;
   logic        rstn;
   logic [3:0]  opcode;
   logic        hltn;
   logic [11:0] ctrl;
   logic [5:0]  tst;

   int checks = 0;
   int errors = 0;

   // Model state: current T-state number (1..6), halt flag, current instruction.
   int         exp_t;
   bit         exp_halt;
   logic [3:0] cur_op;

   sap1_sequencer dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .opcode_i    (opcode),
      .hltn_o      (hltn),
      .ctrl_word_o (ctrl),
      .t_state_o   (tst)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int instr_len(input logic [3:0] op);
`ifdef SAP1_SEQ_EARLY_END_EN
      if (op == 4'h0) return 5;
      if (op == 4'h1 || op == 4'h2) return 6;
      return 4;
`else
      return 6;
`endif
   endfunction

   // Micro-program table: the three execute words for each instruction class.
   function automatic logic [11:0] exp_word(input logic [3:0] op, input int t, input bit halted);
      logic [11:0] fetch [3];
      logic [11:0] exec  [3];
      fetch = '{12'h006, 12'h001, 12'h018};
      case (op)
         4'h0:    exec = '{12'h024, 12'h048, 12'h000};
         4'h1:    exec = '{12'h024, 12'h408, 12'h240};
         4'h2:    exec = '{12'h024, 12'h408, 12'h340};
         4'hE:    exec = '{12'h880, 12'h000, 12'h000};
         default: exec = '{12'h000, 12'h000, 12'h000};
      endcase
      if (halted) return 12'h000;
      if (t <= 3) return fetch[t-1];
      return exec[t-4];
   endfunction

   // One clock: drive opcode, check at the falling edge, then advance the model.
   task automatic cycle();
      logic [5:0] onehot;
      if (exp_t < 4) opcode = 4'($urandom);
      else           opcode = cur_op;
      @(negedge clk);
      onehot = 6'b1 << (exp_t - 1);
      chk("t_state", 16'(tst), 16'(onehot));
      chk("ctrl", 16'(ctrl), 16'(exp_word(cur_op, exp_t, exp_halt)));
      chk("hltn", 16'(hltn), 16'(!(exp_halt || (exp_t == 4 && cur_op == 4'hF))));
      @(posedge clk);
      #1;
      if (exp_halt) begin
         exp_t = 4;
      end else if (exp_t == 4 && cur_op == 4'hF) begin
         exp_halt = 1'b1;
      end else if (exp_t >= instr_len(cur_op)) begin
         exp_t = 1;
      end else begin
         exp_t++;
      end
   endtask

   task automatic run_instr(input logic [3:0] op);
      int n;
      cur_op = op;
      n = 0;
      do begin
         cycle();
         n++;
      end while (exp_t != 1 && n < 8);
   endtask

   task automatic model_reset();
      exp_t    = 1;
      exp_halt = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         chk("onehot", 16'($onehot(tst)), 16'd1);
         chk("one_driver", 16'($countones(ctrl & 12'h2AA) <= 1), 16'd1);
      end
   end

   initial begin
      int total;
      int n;
      logic [3:0] prog [3];
      rstn   = 1'b0;
      opcode = 4'h7;
      cur_op = 4'h0;
      model_reset();

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_t_state", 16'(tst), 16'h01);
      chk("rst_ctrl", 16'(ctrl), 16'h006);
      chk("rst_hltn", 16'(hltn), 16'd1);
      @(posedge clk);
      #1 rstn = 1'b1;

      run_instr(4'h0);
      chk("lda_back_to_t1", 16'(tst), 16'h01);
      run_instr(4'h1);
      run_instr(4'h2);
      run_instr(4'hE);
      run_instr(4'h5);

      // HLT: freeze at T4 for the following clocks.
      cur_op = 4'hF;
      repeat (14) cycle();
      chk("hlt_hold_t", 16'(tst), 16'h08);
      chk("hlt_hold_hltn", 16'(hltn), 16'd0);
      rstn = 1'b0;
      #2;
      model_reset();
      chk("hlt_rst_t", 16'(tst), 16'h01);
      chk("hlt_rst_ctrl", 16'(ctrl), 16'h006);
      chk("hlt_rst_hltn", 16'(hltn), 16'd1);
      @(posedge clk);
      #1 rstn = 1'b1;

      // Asynchronous reset during ADD T5, no clock edge in between.
      cur_op = 4'h1;
      repeat (4) cycle();
      chk("pre_async_t5", 16'(tst), 16'h10);
      #2 rstn = 1'b0;
      #1;
      model_reset();
      chk("async_t", 16'(tst), 16'h01);
      chk("async_ctrl", 16'(ctrl), 16'h006);
      @(posedge clk);
      #1 rstn = 1'b1;

      for (int i = 0; i < 40; i++) begin
         run_instr(4'($urandom_range(0, 14)));
      end

      // Program LDA, ADD, OUT then HLT; count DUT edges per instruction.
      prog  = '{4'h0, 4'h1, 4'hE};
      total = 0;
      for (int i = 0; i < 3; i++) begin
         cur_op = prog[i];
         n = 0;
         do begin
            cycle();
            n++;
         end while (tst != 6'h01 && n < 10);
         total += n;
      end
`ifdef SAP1_SEQ_EARLY_END_EN
      chk("prog_cycles", 16'(total), 16'd15);
`else
      chk("prog_cycles", 16'(total), 16'd18);
`endif
      cur_op = 4'hF;
      repeat (6) cycle();
      chk("prog_halted", 16'(hltn), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
